ns_msg_fifo: RTL and testbench



---
 rtl/ns_msg_fifo_pkg.sv | 52 +++++
 rtl/ns_msg_fifo_if.sv | 20 ++
 rtl/ns_msg_fifo_calc_redun.sv | 25 ++
 rtl/ns_msg_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_ns_msg_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ns_msg_fifo_pkg.sv
// Shared definitions for ns_msg_fifo: default message field widths, handshake
// debounce lengths, NS_ON/NS_OFF and the state encodings of both channel FSMs.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 1
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 1
`endif

package ns_msg_fifo_pkg;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam int NS_ASZ      = `NS_ADDRESS_SIZE;
  localparam int NS_DSZ      = `NS_DATA_SIZE;
  localparam int NS_RSZ      = `NS_REDUN_SIZE;
  localparam int NS_REQ_CKS_DEF = `NS_REQ_CKS;
  localparam int NS_ACK_CKS_DEF = `NS_ACK_CKS;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_LOAD = 2'd1,
    OUT_REQ  = 2'd2,
    OUT_REL  = 2'd3
  } out_state_e;

  typedef struct packed {
    in_state_e  in_state;
    out_state_e out_state;
  } fifo_dbg_t;

  // Stored message is {src, dst, dat, red}.
  function automatic int msg_width(input int asz, input int dsz, input int rsz);
    return 2 * asz + dsz + rsz;
  endfunction

endpackage

// File: rtl/ns_msg_fifo_if.sv
// Message channel: src/dst/dat/red plus a 4-phase req/ack pair.
// 4-phase handshake: the master presents fields, then raises req; the slave
// raises ack once it has taken them; master drops req, then slave drops ack.
interface ns_msg_fifo_if
  import ns_msg_fifo_pkg::*;
#(
  parameter int ASZ = NS_ASZ,
  parameter int DSZ = NS_DSZ,
  parameter int RSZ = NS_RSZ
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, output dst, output dat, output red, output req, input ack);
  modport slave  (input src, input dst, input dat, input red, input req, output ack);
endinterface

// File: rtl/ns_msg_fifo_calc_redun.sv
// calc_redun: redundancy of a message as an XOR fold of {src, dst, dat}
// onto RSZ bits (bit i of the concatenation lands on red[i % RSZ]).
module calc_redun #(
  parameter int ASZ = 4,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);
  localparam int W = 2 * ASZ + DSZ;

  logic [W-1:0] bits;

  assign bits = {src, dst, dat};

  always_comb begin
    red = '0;
    for (int i = 0; i < W; i++) begin
      red[i % RSZ] = red[i % RSZ] ^ bits[i];
    end
  end
endmodule

// File: rtl/ns_msg_fifo.sv
// ns_msg_fifo: DEPTH-entry message buffer between two debounced 4-phase channels.
// Optional input redundancy check: define NS_MSG_FIFO_REDUN_CHK_EN.
module ns_msg_fifo
  import ns_msg_fifo_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ASZ         = NS_ASZ,
  parameter int DSZ         = NS_DSZ,
  parameter int RSZ         = NS_RSZ,
  parameter int RCV_REQ_CKS = NS_REQ_CKS_DEF,
  parameter int SND_ACK_CKS = NS_ACK_CKS_DEF
) (
  input  logic                     src_clk,
  input  logic                     rst_n,
  ns_msg_fifo_if.slave             i0,
  ns_msg_fifo_if.master            o0,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  output fifo_dbg_t                dbg
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int MW  = msg_width(ASZ, DSZ, RSZ);
  localparam int RCW = $clog2(RCV_REQ_CKS + 1);
  localparam int SCW = $clog2(SND_ACK_CKS + 1);

  localparam logic [RCW-1:0] RCV_LAST = RCW'(RCV_REQ_CKS - 1);
  localparam logic [SCW-1:0] SND_LAST = SCW'(SND_ACK_CKS - 1);

  // ---------------------------------------------------------------- storage
  logic [MW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  logic          full;
  logic          wr_en;
  logic          pop;

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Contents need no reset: a slot is only read after it has been written.
  always_ff @(posedge src_clk) begin
    if (wr_en) begin
      mem[wp] <= {i0.src, i0.dst, i0.dat, i0.red};
    end
  end

  always_comb begin
    count_n = count_q;
    if (wr_en && !pop) begin
      count_n = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_n = count_q - CW'(1);
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wp <= wp + PW'(1);
      if (pop)   rp <= rp + PW'(1);
      count_q <= count_n;
    end
  end

  // ---------------------------------------------------------------- input FSM
  in_state_e      in_state;
  in_state_e      in_state_n;
  logic [RCW-1:0] in_cnt;
  logic [RCW-1:0] in_cnt_n;
  logic           i0_ack_q;
  logic           i0_ack_n;
  logic           accept;

  // While full the debounce count saturates, so acceptance follows on the
  // first cycle a slot frees up without re-qualifying i0_req.
  always_comb begin
    in_state_n = in_state;
    in_cnt_n   = in_cnt;
    i0_ack_n   = i0_ack_q;
    accept     = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (!i0.req) begin
          in_cnt_n = '0;
        end else if (in_cnt >= RCV_LAST) begin
          if (!full) begin
            accept     = 1'b1;
            i0_ack_n   = 1'b1;
            in_cnt_n   = '0;
            in_state_n = IN_ACK;
          end
        end else begin
          in_cnt_n = in_cnt + RCW'(1);
        end
      end
      IN_ACK: begin
        if (i0.req) begin
          in_cnt_n = '0;
        end else if (in_cnt >= RCV_LAST) begin
          i0_ack_n   = 1'b0;
          in_cnt_n   = '0;
          in_state_n = IN_IDLE;
        end else begin
          in_cnt_n = in_cnt + RCW'(1);
        end
      end
      default: begin
        in_state_n = IN_IDLE;
        in_cnt_n   = '0;
        i0_ack_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state <= IN_IDLE;
      in_cnt   <= '0;
      i0_ack_q <= 1'b0;
    end else begin
      in_state <= in_state_n;
      in_cnt   <= in_cnt_n;
      i0_ack_q <= i0_ack_n;
    end
  end

  assign i0.ack = i0_ack_q;

  // ---------------------------------------------------------------- output FSM
  out_state_e     out_state;
  out_state_e     out_state_n;
  logic [SCW-1:0] out_cnt;
  logic [SCW-1:0] out_cnt_n;
  logic           o0_req_q;
  logic           o0_req_n;
  logic           load;
  logic [MW-1:0]  head_q;

  always_comb begin
    out_state_n = out_state;
    out_cnt_n   = out_cnt;
    o0_req_n    = o0_req_q;
    load        = 1'b0;
    pop         = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if ((count_q != '0) && !o0.ack) begin
          load        = 1'b1;
          out_state_n = OUT_LOAD;
        end
      end
      OUT_LOAD: begin
        // Fields went out last cycle; req follows one cycle behind them.
        o0_req_n    = 1'b1;
        out_cnt_n   = '0;
        out_state_n = OUT_REQ;
      end
      OUT_REQ: begin
        if (!o0.ack) begin
          out_cnt_n = '0;
        end else if (out_cnt >= SND_LAST) begin
          pop         = 1'b1;
          o0_req_n    = 1'b0;
          out_cnt_n   = '0;
          out_state_n = OUT_REL;
        end else begin
          out_cnt_n = out_cnt + SCW'(1);
        end
      end
      OUT_REL: begin
        if (o0.ack) begin
          out_cnt_n = '0;
        end else if (out_cnt >= SND_LAST) begin
          out_cnt_n   = '0;
          out_state_n = OUT_IDLE;
        end else begin
          out_cnt_n = out_cnt + SCW'(1);
        end
      end
      default: begin
        out_state_n = OUT_IDLE;
        out_cnt_n   = '0;
        o0_req_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= OUT_IDLE;
      out_cnt   <= '0;
      o0_req_q  <= 1'b0;
      head_q    <= '0;
    end else begin
      out_state <= out_state_n;
      out_cnt   <= out_cnt_n;
      o0_req_q  <= o0_req_n;
      if (load) head_q <= mem[rp];
    end
  end

  assign {o0.src, o0.dst, o0.dat, o0.red} = head_q;
  assign o0.req = o0_req_q;

  // ---------------------------------------------------------------- redundancy
`ifdef NS_MSG_FIFO_REDUN_CHK_EN
  logic [RSZ-1:0] red_calc;
  logic           red_ok;
  logic           err_q;

  calc_redun #(
    .ASZ (ASZ),
    .DSZ (DSZ),
    .RSZ (RSZ)
  ) u_calc_redun (
    .src (i0.src),
    .dst (i0.dst),
    .dat (i0.dat),
    .red (red_calc)
  );

  // A corrupted message still completes its handshake; it is just dropped.
  assign red_ok = (red_calc == i0.red);
  assign wr_en  = accept & red_ok;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= NS_OFF;
    end else if (accept && !red_ok) begin
      err_q <= NS_ON;
    end
  end

  assign err = err_q;
`else
  assign wr_en = accept;
  assign err   = NS_OFF;
`endif

  always_comb begin
    dbg.in_state  = in_state;
    dbg.out_state = out_state;
  end

endmodule

// File: tb/tb_ns_msg_fifo.sv
// Bench for ns_msg_fifo: random messages through a producer and a sink, checked
// in arrival order against a queue model; debounce, full and reset cases.
module tb_ns_msg_fifo;
  import ns_msg_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int ASZ   = 4;
  localparam int DSZ   = 8;
  localparam int RSZ   = 4;
  localparam int RCV   = 3;
  localparam int SND   = 2;
  localparam int MW    = 2 * ASZ + DSZ + RSZ;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------- clock / reset
  logic src_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 src_clk = ~src_clk;

  logic [CW-1:0] count;
  logic          err;
  fifo_dbg_t     dbg;

  ns_msg_fifo_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i0 ();
  ns_msg_fifo_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) o0 ();

  ns_msg_fifo #(
    .DEPTH(DEPTH), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
    .RCV_REQ_CKS(RCV), .SND_ACK_CKS(SND)
  ) dut (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .i0      (i0),
    .o0      (o0),
    .count   (count),
    .err     (err),
    .dbg     (dbg)
  );

  // ---------------------------------------------------------------- model state
  int            vectors     = 0;
  int            miscompares = 0;
  logic [MW-1:0] exp_q[$];
  int            acc_n  = 0;
  int            sunk_n = 0;
  int            rx_n   = 0;
  bit            sink_en = 1'b0;
  bit            exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [RSZ-1:0] ref_red(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                             input logic [DSZ-1:0] dt);
    logic [2*ASZ+DSZ-1:0] v;
    logic [RSZ-1:0]       r;
    v = {s, d, dt};
    r = '0;
    for (int k = 0; k * RSZ < 2 * ASZ + DSZ; k++) begin
      r = r ^ v[RSZ-1:0];
      v = v >> RSZ;
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] make_msg(input logic [DSZ-1:0] dt);
    logic [ASZ-1:0] s;
    logic [ASZ-1:0] d;
    s = ASZ'($urandom_range(0, (1 << ASZ) - 1));
    d = ASZ'($urandom_range(0, (1 << ASZ) - 1));
    return {s, d, dt, ref_red(s, d, dt)};
  endfunction

  function automatic int occ();
    return acc_n - sunk_n;
  endfunction

  // An acknowledged message is expected downstream unless the redundancy check drops it.
  task automatic accept_model(input logic [MW-1:0] m);
`ifdef NS_MSG_FIFO_REDUN_CHK_EN
    if (m[RSZ-1:0] != ref_red(m[MW-1 -: ASZ], m[MW-ASZ-1 -: ASZ], m[RSZ +: DSZ])) begin
      exp_err = 1'b1;
    end else begin
      exp_q.push_back(m);
      acc_n++;
    end
`else
    exp_q.push_back(m);
    acc_n++;
`endif
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic raise_req(input logic [MW-1:0] m);
    {i0.src, i0.dst, i0.dat, i0.red} = m;
    i0.req = 1'b1;
  endtask

  task automatic wait_ack(input int bound, input logic [MW-1:0] m, output bit ok);
    int t = 0;
    while (!i0.ack && t < bound) begin
      @(negedge src_clk);
      t++;
    end
    ok = i0.ack;
    if (ok) accept_model(m);
  endtask

  task automatic drop_req();
    int t = 0;
    i0.req = 1'b0;
    while (i0.ack && t < 50) begin
      @(negedge src_clk);
      t++;
    end
    if (i0.ack) check("ack_release", 32'(i0.ack), 32'd0);
  endtask

  task automatic send(input logic [MW-1:0] m, input int bound, output bit ok);
    raise_req(m);
    wait_ack(bound, m, ok);
    drop_req();
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((count != '0 || o0.req || o0.ack || i0.ack || exp_q.size() != 0) && t < 3000) begin
      @(negedge src_clk);
      t++;
    end
    repeat (4) @(negedge src_clk);
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_req"}, 32'(o0.req), 32'd0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------- sink
  initial begin
    o0.ack = 1'b0;
    forever begin
      @(negedge src_clk);
      if (sink_en && rst_n && o0.req) begin
        int t;
        repeat ($urandom_range(0, 3)) @(negedge src_clk);
        o0.ack = 1'b1;
        t = 0;
        while (o0.req && t < 50) begin
          @(negedge src_clk);
          t++;
        end
        if (o0.req) check("sink_req_drop", 32'(o0.req), 32'd0);
        o0.ack = 1'b0;
        sunk_n++;
      end
    end
  end

  // ---------------------------------------------------------------- monitor / scoreboard
  initial begin
    logic req_prev;
    logic [MW-1:0] got;
    req_prev = 1'b0;
    forever begin
      @(negedge src_clk);
      if (!rst_n) begin
        req_prev = 1'b0;
      end else begin
        check("count_bound", 32'(count <= CW'(DEPTH)), 32'd1);
        if (o0.req && !req_prev) begin
          got = {o0.src, o0.dst, o0.dat, o0.red};
          rx_n++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_msg: got %0h required none", got);
          end else begin
            check("msg_order", 32'(got), 32'(exp_q.pop_front()));
          end
        end
        req_prev = o0.req;
      end
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main sequence
  initial begin
    bit            ok;
    bit            seen;
    int            rx_base;
    logic [MW-1:0] m;

    i0.req = 1'b0;
    {i0.src, i0.dst, i0.dat, i0.red} = '0;
    repeat (3) @(negedge src_clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_o0_req", 32'(o0.req), 32'd0);
    check("rst_i0_ack", 32'(i0.ack), 32'd0);
    check("rst_o0_msg", 32'({o0.src, o0.dst, o0.dat, o0.red}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge src_clk);

    // Fill with the sink stalled, then a fifth request must wait.
    rx_base = rx_n;
    for (int d = 0; d < DEPTH; d++) begin
      send(make_msg(DSZ'(d)), 100, ok);
      check("fill_ack", 32'(ok), 32'd1);
    end
    repeat (4) @(negedge src_clk);
    check("full_count", 32'(count), 32'(occ()));
    check("head_dat", 32'(o0.dat), 32'd0);
    check("head_req", 32'(o0.req), 32'd1);
    m = make_msg(DSZ'(DEPTH));
    raise_req(m);
    wait_ack(20, m, ok);
    check("full_no_ack", 32'(ok), 32'd0);
    check("full_hold", 32'(count), 32'(DEPTH));
    sink_en = 1'b1;
    wait_ack(200, m, ok);
    check("stall_accept", 32'(ok), 32'd1);
    drop_req();
    wait_drain("drain_full");
    check("drain_full_rx", 32'(rx_n - rx_base), 32'(DEPTH + 1));

    // Request debounce: a 2-cycle pulse is ignored, a 3-cycle pulse is taken.
    sink_en = 1'b0;
    m = make_msg(8'hA5);
    {i0.src, i0.dst, i0.dat, i0.red} = m;
    seen = 1'b0;
    i0.req = 1'b1;
    repeat (RCV - 1) begin
      @(negedge src_clk);
      if (i0.ack) seen = 1'b1;
    end
    i0.req = 1'b0;
    repeat (8) begin
      @(negedge src_clk);
      if (i0.ack) seen = 1'b1;
    end
    check("short_pulse_ack", 32'(seen), 32'd0);
    check("short_pulse_count", 32'(count), 32'(occ()));
    i0.req = 1'b1;
    repeat (RCV) begin
      @(negedge src_clk);
      if (i0.ack) seen = 1'b1;
    end
    i0.req = 1'b0;
    if (seen) accept_model(m);
    repeat (8) @(negedge src_clk);
    check("pulse_ack", 32'(seen), 32'd1);
    check("pulse_count", 32'(count), 32'(occ()));
    sink_en = 1'b1;
    wait_drain("drain_pulse");

    // Continuous random traffic, pointers wrapping many times.
    rx_base = rx_n;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge src_clk);
      send(make_msg(DSZ'($urandom_range(0, 255))), 500, ok);
      check("stream_ack", 32'(ok), 32'd1);
    end
    wait_drain("drain_stream");
    check("stream_rx", 32'(rx_n - rx_base), 32'd40);

    // Reset while a message is being offered with two stored.
    sink_en = 1'b0;
    repeat (4) @(negedge src_clk);
    for (int i = 0; i < 2; i++) begin
      send(make_msg(DSZ'(8'h40 + i)), 100, ok);
      check("pre_rst_ack", 32'(ok), 32'd1);
    end
    begin
      int t = 0;
      while (!o0.req && t < 20) begin
        @(negedge src_clk);
        t++;
      end
    end
    check("pre_rst_req", 32'(o0.req), 32'd1);
    check("pre_rst_count", 32'(count), 32'(occ()));
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(o0.req), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ack", 32'(i0.ack), 32'd0);
    check("mid_rst_dat", 32'(o0.dat), 32'd0);
    exp_q.delete();
    acc_n  = 0;
    sunk_n = 0;
    repeat (2) @(negedge src_clk);
    rst_n = 1'b1;
    @(negedge src_clk);
    rx_base = rx_n;
    send(make_msg(8'h77), 100, ok);
    check("post_rst_ack", 32'(ok), 32'd1);
    sink_en = 1'b1;
    wait_drain("drain_post_rst");
    check("post_rst_rx", 32'(rx_n - rx_base), 32'd1);

`ifdef NS_MSG_FIFO_REDUN_CHK_EN
    // Corrupted redundancy: handshake completes, nothing stored, err sticks.
    sink_en = 1'b0;
    m = make_msg(8'h3C);
    m[0] = ~m[0];
    send(m, 100, ok);
    check("bad_red_ack", 32'(ok), 32'd1);
    repeat (4) @(negedge src_clk);
    check("bad_red_count", 32'(count), 32'(occ()));
    check("bad_red_err", 32'(err), 32'(exp_err));
    send(make_msg(8'h3D), 100, ok);
    repeat (4) @(negedge src_clk);
    check("good_after_bad_count", 32'(count), 32'(occ()));
    sink_en = 1'b1;
    wait_drain("drain_redun");
`endif

    check("err_final", 32'(err), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
